// File: rtl/fadd_sub_pipe.sv
// Three-stage elastic IEEE-754 add/subtract: S1 unpack/swap/align, S2 add/normalise, S3 round/pack/flags.
// Special operands (NaN/Inf) are resolved in S1 and override the datapath result in S3.
module fadd_sub_pipe #(
    parameter int EXPWIDTH   = 5,
    parameter int PRECISION  = 10,
    parameter int CTRL_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [EXPWIDTH+PRECISION:0] a_i,
    input  logic [EXPWIDTH+PRECISION:0] b_i,
    input  logic                        op_i,
    input  logic [2:0]                  rm_i,
    input  logic [CTRL_WIDTH-1:0]       ctrl_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [EXPWIDTH+PRECISION:0] result_o,
    output logic [4:0]                  fflags_o,
    output logic [CTRL_WIDTH-1:0]       ctrl_o
);
    localparam int W  = EXPWIDTH + PRECISION + 1;
    localparam int MW = PRECISION + 4;
    localparam int XW = EXPWIDTH + 2;
    localparam int RW = PRECISION + 2;
    localparam logic [XW-1:0]       MW_X     = XW'(MW);
    localparam logic [XW-1:0]       EMAX     = XW'((1 << EXPWIDTH) - 1);
    localparam logic [EXPWIDTH-1:0] EXP_MAXF = {{(EXPWIDTH-1){1'b1}}, 1'b0};
    localparam logic [W-1:0]        QNAN     = {1'b0, {EXPWIDTH{1'b1}}, 1'b1, {(PRECISION-1){1'b0}}};
    localparam logic [2:0] RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4;

    typedef struct packed {
        logic                  sign;
        logic                  sub;
        logic [XW-1:0]         exp;
        logic [MW-1:0]         ml;
        logic [MW-1:0]         ms;
        logic [2:0]            rm;
        logic                  sp;
        logic                  sp_nv;
        logic [W-1:0]          sp_res;
        logic [CTRL_WIDTH-1:0] ctrl;
    } s1_t;

    typedef struct packed {
        logic                  sign;
        logic                  zero;
        logic [XW-1:0]         exp;
        logic [MW-1:0]         mant;
        logic [2:0]            rm;
        logic                  sp;
        logic                  sp_nv;
        logic [W-1:0]          sp_res;
        logic [CTRL_WIDTH-1:0] ctrl;
    } s2_t;

    typedef struct packed {
        logic [W-1:0]          res;
        logic [4:0]            flags;
        logic [CTRL_WIDTH-1:0] ctrl;
    } s3_t;

    logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    s1_t  s1_q, s1_d;
    s2_t  s2_q, s2_d;
    s3_t  s3_q, s3_d;

    logic adv1, adv2, adv3;
    assign adv3       = !v3_q || out_ready_i;
    assign adv2       = !v2_q || adv3;
    assign adv1       = !v1_q || adv2;
    assign in_ready_o = adv1;

    // Per-operand unpack; B's sign already carries the add/sub selection.
    logic [W-1:0]       opnd   [2];
    logic               u_sign [2];
    logic               u_nan  [2];
    logic               u_snan [2];
    logic               u_inf  [2];
    logic [XW-1:0]      u_exp  [2];
    logic [PRECISION:0] u_mant [2];

    assign opnd[0] = a_i;
    assign opnd[1] = b_i;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            logic [EXPWIDTH-1:0]  ef;
            logic [PRECISION-1:0] ff;
            assign ef         = opnd[gi][W-2:PRECISION];
            assign ff         = opnd[gi][PRECISION-1:0];
            assign u_sign[gi] = opnd[gi][W-1] ^ (op_i && (gi == 1));
            assign u_nan[gi]  = (&ef) && (|ff);
            assign u_snan[gi] = (&ef) && (|ff) && !ff[PRECISION-1];
            assign u_inf[gi]  = (&ef) && !(|ff);
            assign u_exp[gi]  = (ef == '0) ? XW'(1) : XW'(ef);
            assign u_mant[gi] = {|ef, ff};
        end
    endgenerate

    // S1: swap so the larger magnitude is first, then align the smaller one with sticky.
    logic               a_big, sp_hit, sp_nv;
    logic [W-1:0]       sp_res;
    logic [XW-1:0]      exp_l, exp_s, diff;
    logic [PRECISION:0] mant_l, mant_s;
    logic [MW-1:0]      ext_s, aligned;
    logic [2:0]         rm_n;

    always_comb begin
        a_big  = {u_exp[0], u_mant[0]} >= {u_exp[1], u_mant[1]};
        exp_l  = a_big ? u_exp[0] : u_exp[1];
        exp_s  = a_big ? u_exp[1] : u_exp[0];
        mant_l = a_big ? u_mant[0] : u_mant[1];
        mant_s = a_big ? u_mant[1] : u_mant[0];
        diff   = exp_l - exp_s;
        ext_s  = {mant_s, 3'b000};
        if (diff >= MW_X) begin
            aligned    = '0;
            aligned[0] = |mant_s;
        end else begin
            aligned    = ext_s >> diff;
            aligned[0] = aligned[0] | (|(ext_s & ~({MW{1'b1}} << diff)));
        end
        rm_n   = (rm_i > RMM) ? RNE : rm_i;
        sp_hit = 1'b1;
        sp_nv  = 1'b0;
        sp_res = QNAN;
        if (u_nan[0] || u_nan[1]) begin
            sp_nv = u_snan[0] || u_snan[1];
        end else if (u_inf[0] && u_inf[1] && (u_sign[0] != u_sign[1])) begin
            sp_nv = 1'b1;
        end else if (u_inf[0]) begin
            sp_res = {u_sign[0], {EXPWIDTH{1'b1}}, {PRECISION{1'b0}}};
        end else if (u_inf[1]) begin
            sp_res = {u_sign[1], {EXPWIDTH{1'b1}}, {PRECISION{1'b0}}};
        end else begin
            sp_hit = 1'b0;
        end
    end

    // S2: magnitude add/subtract, then normalise without pushing below exponent 1.
    logic [MW:0]   sum;
    logic [XW-1:0] lz, lim, sh, norm_exp;
    logic [MW-1:0] norm_mant;
    logic          sum_zero;

    always_comb begin
        sum = s1_q.sub ? ({1'b0, s1_q.ml} - {1'b0, s1_q.ms}) : ({1'b0, s1_q.ml} + {1'b0, s1_q.ms});
        lz  = MW_X;
        for (int i = 0; i < MW; i++) begin
            if (sum[i]) lz = XW'(MW - 1 - i);
        end
        lim = s1_q.exp - XW'(1);
        sh  = (lz < lim) ? lz : lim;
        if (sum[MW]) begin
            norm_mant = sum[MW:1] | {{(MW-1){1'b0}}, sum[0]};
            norm_exp  = s1_q.exp + XW'(1);
        end else begin
            norm_mant = sum[MW-1:0] << sh;
            norm_exp  = s1_q.exp - sh;
        end
        sum_zero = (sum == '0);
    end

    // S3: round on G/R/S, renormalise a rounding carry, detect overflow, pack.
    logic            lsb, grd, rs, inexact, up, hid, ovf, nx;
    logic [RW-1:0]   rounded;
    logic [XW-1:0]   rexp;
    logic [PRECISION-1:0] frac;
    logic [EXPWIDTH-1:0]  pexp;
    logic [W-1:0]    p_res, ovf_res;
    logic [4:0]      p_flags;

    always_comb begin
        lsb     = s2_q.mant[3];
        grd     = s2_q.mant[2];
        rs      = s2_q.mant[1] | s2_q.mant[0];
        inexact = grd | rs;
        case (s2_q.rm)
            RTZ:     up = 1'b0;
            RDN:     up = inexact && s2_q.sign;
            RUP:     up = inexact && !s2_q.sign;
            RMM:     up = grd;
            default: up = grd && (rs || lsb);
        endcase
        rounded = {1'b0, s2_q.mant[MW-1:3]} + RW'(up);
        if (rounded[RW-1]) begin
            hid  = 1'b1;
            frac = rounded[PRECISION:1];
            rexp = s2_q.exp + XW'(1);
        end else begin
            hid  = rounded[PRECISION];
            frac = rounded[PRECISION-1:0];
            rexp = s2_q.exp;
        end
        ovf  = rexp >= EMAX;
        nx   = inexact || ovf;
        pexp = hid ? rexp[EXPWIDTH-1:0] : '0;
        case (s2_q.rm)
            RTZ:     ovf_res = {s2_q.sign, EXP_MAXF, {PRECISION{1'b1}}};
            RDN:     ovf_res = s2_q.sign ? {1'b1, {EXPWIDTH{1'b1}}, {PRECISION{1'b0}}}
                                         : {1'b0, EXP_MAXF, {PRECISION{1'b1}}};
            RUP:     ovf_res = s2_q.sign ? {1'b1, EXP_MAXF, {PRECISION{1'b1}}}
                                         : {1'b0, {EXPWIDTH{1'b1}}, {PRECISION{1'b0}}};
            default: ovf_res = {s2_q.sign, {EXPWIDTH{1'b1}}, {PRECISION{1'b0}}};
        endcase
        if (s2_q.sp) begin
            p_res   = s2_q.sp_res;
            p_flags = {s2_q.sp_nv, 4'b0000};
        end else if (s2_q.zero) begin
            p_res   = {s2_q.sign, {(W-1){1'b0}}};
            p_flags = 5'b00000;
        end else if (ovf) begin
            p_res   = ovf_res;
            p_flags = 5'b00101;
        end else begin
            p_res   = {s2_q.sign, pexp, frac};
            p_flags = {3'b000, nx && (pexp == '0), nx};
        end
    end

    // Each stage loads only when it advances and its upstream holds a valid op.
    always_comb begin
        v1_d = v1_q;
        v2_d = v2_q;
        v3_d = v3_q;
        s1_d = s1_q;
        s2_d = s2_q;
        s3_d = s3_q;
        if (adv1) begin
            v1_d = in_valid_i;
            if (in_valid_i) begin
                s1_d.sign   = a_big ? u_sign[0] : u_sign[1];
                s1_d.sub    = u_sign[0] ^ u_sign[1];
                s1_d.exp    = exp_l;
                s1_d.ml     = {mant_l, 3'b000};
                s1_d.ms     = aligned;
                s1_d.rm     = rm_n;
                s1_d.sp     = sp_hit;
                s1_d.sp_nv  = sp_nv;
                s1_d.sp_res = sp_res;
                s1_d.ctrl   = ctrl_i;
            end
        end
        if (adv2) begin
            v2_d = v1_q;
            if (v1_q) begin
                s2_d.sign   = (sum_zero && s1_q.sub) ? (s1_q.rm == RDN) : s1_q.sign;
                s2_d.zero   = sum_zero;
                s2_d.exp    = norm_exp;
                s2_d.mant   = norm_mant;
                s2_d.rm     = s1_q.rm;
                s2_d.sp     = s1_q.sp;
                s2_d.sp_nv  = s1_q.sp_nv;
                s2_d.sp_res = s1_q.sp_res;
                s2_d.ctrl   = s1_q.ctrl;
            end
        end
        if (adv3) begin
            v3_d = v2_q;
            if (v2_q) begin
                s3_d.res   = p_res;
                s3_d.flags = p_flags;
                s3_d.ctrl  = s2_q.ctrl;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            v3_q <= v3_d;
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign out_valid_o = v3_q;
    assign result_o    = s3_q.res;
    assign fflags_o    = s3_q.flags;
    assign ctrl_o      = s3_q.ctrl;
endmodule

// File: tb/tb_fadd_sub_pipe.sv
// Bench for fadd_sub_pipe: half-precision vector table driven through a scoreboard,
// plus latency, backpressure/stall and mid-flight reset sequences.
module tb_fadd_sub_pipe;
    localparam int NV = 34;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        op = 1'b0;
    logic [2:0]  rm = '0;
    logic [31:0] ctrl_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] result;
    logic [4:0]  fflags;
    logic [31:0] ctrl_out;

    always #5 clk = ~clk;

    fadd_sub_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .a_i        (a),
        .b_i        (b),
        .op_i       (op),
        .rm_i       (rm),
        .ctrl_i     (ctrl_in),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .result_o   (result),
        .fflags_o   (fflags),
        .ctrl_o     (ctrl_out)
    );

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        op;
        logic [2:0]  rm;
        logic [15:0] res;
        logic [4:0]  flags;
    } vec_t;

    typedef struct packed {
        logic [15:0] res;
        logic [4:0]  flags;
        logic [31:0] ctrl;
    } exp_t;

    vec_t vecs [NV];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic send(input vec_t v, input logic [31:0] tag);
        bit ok = 1'b0;
        int t  = 0;
        a = v.a; b = v.b; op = v.op; rm = v.rm; ctrl_in = tag; in_valid = 1'b1;
        while (!ok && t < 200) begin
            @(negedge clk);
            ok = in_ready;
            if (ok) sb.push_back('{v.res, v.flags, tag});
            @(posedge clk); #1;
            t++;
        end
        in_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout: tag %h never accepted", tag);
        end
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d results still outstanding, want 0", name, sb.size());
        end
    endtask

    // Output monitor: pops the scoreboard on every accepted beat and checks hold stability under stall.
    logic        hold_pend = 1'b0;
    logic [15:0] hold_res;
    logic [4:0]  hold_flags;
    logic [31:0] hold_ctrl;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_pend = 1'b0;
            end else begin
                if (hold_pend) begin
                    checks++;
                    if (!out_valid || result !== hold_res || fflags !== hold_flags || ctrl_out !== hold_ctrl) begin
                        errors++;
                        $display("FAIL hold_stable: got v=%b res=%h fl=%h ctrl=%h, want v=1 res=%h fl=%h ctrl=%h",
                                 out_valid, result, fflags, ctrl_out, hold_res, hold_flags, hold_ctrl);
                    end
                end
                hold_pend  = out_valid && !out_ready;
                hold_res   = result;
                hold_flags = fflags;
                hold_ctrl  = ctrl_out;
                if (out_valid && out_ready) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_out: got res=%h ctrl=%h, want no output", result, ctrl_out);
                    end else begin
                        e = sb.pop_front();
                        $display("out ctrl=%h res=%h flags=%h (want res=%h flags=%h ctrl=%h)",
                                 ctrl_out, result, fflags, e.res, e.flags, e.ctrl);
                        if (result !== e.res || fflags !== e.flags || ctrl_out !== e.ctrl) begin
                            errors++;
                            $display("FAIL result_tag %h: got res=%h fl=%h ctrl=%h, want res=%h fl=%h ctrl=%h",
                                     e.ctrl, result, fflags, ctrl_out, e.res, e.flags, e.ctrl);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //           a         b         op    rm     res       flags
        vecs[0]  = '{16'h3C00, 16'h3C00, 1'b0, 3'd0, 16'h4000, 5'h00};
        vecs[1]  = '{16'h7C00, 16'h7C00, 1'b1, 3'd0, 16'h7E00, 5'h10};
        vecs[2]  = '{16'h7D00, 16'h3C00, 1'b0, 3'd0, 16'h7E00, 5'h10};
        vecs[3]  = '{16'h7BFF, 16'h7BFF, 1'b0, 3'd0, 16'h7C00, 5'h05};
        vecs[4]  = '{16'h7BFF, 16'h7BFF, 1'b0, 3'd1, 16'h7BFF, 5'h05};
        vecs[5]  = '{16'hFBFF, 16'hFBFF, 1'b0, 3'd2, 16'hFC00, 5'h05};
        vecs[6]  = '{16'h3C00, 16'h3C00, 1'b1, 3'd0, 16'h0000, 5'h00};
        vecs[7]  = '{16'h3C00, 16'h3C00, 1'b1, 3'd2, 16'h8000, 5'h00};
        vecs[8]  = '{16'h3C00, 16'h1000, 1'b0, 3'd0, 16'h3C00, 5'h01};
        vecs[9]  = '{16'h3C00, 16'h1000, 1'b0, 3'd3, 16'h3C01, 5'h01};
        vecs[10] = '{16'h0001, 16'h0001, 1'b0, 3'd0, 16'h0002, 5'h00};
        vecs[11] = '{16'h8000, 16'h8000, 1'b0, 3'd0, 16'h8000, 5'h00};
        vecs[12] = '{16'h7C00, 16'h3C00, 1'b1, 3'd0, 16'h7C00, 5'h00};
        vecs[13] = '{16'h3C00, 16'hFC00, 1'b0, 3'd0, 16'hFC00, 5'h00};
        vecs[14] = '{16'h7E00, 16'h3C00, 1'b0, 3'd0, 16'h7E00, 5'h00};
        vecs[15] = '{16'h3C00, 16'h1000, 1'b0, 3'd4, 16'h3C01, 5'h01};
        vecs[16] = '{16'h3C00, 16'h1000, 1'b0, 3'd1, 16'h3C00, 5'h01};
        vecs[17] = '{16'h3C00, 16'h1000, 1'b0, 3'd5, 16'h3C00, 5'h01};
        vecs[18] = '{16'h0400, 16'h0001, 1'b1, 3'd0, 16'h03FF, 5'h00};
        vecs[19] = '{16'h3C00, 16'h0001, 1'b0, 3'd0, 16'h3C00, 5'h01};
        vecs[20] = '{16'h3C00, 16'h0001, 1'b0, 3'd3, 16'h3C01, 5'h01};
        vecs[21] = '{16'h3C00, 16'h0001, 1'b1, 3'd1, 16'h3BFF, 5'h01};
        vecs[22] = '{16'h3C00, 16'h3C01, 1'b0, 3'd0, 16'h4000, 5'h01};
        vecs[23] = '{16'h4000, 16'h3C00, 1'b1, 3'd0, 16'h3C00, 5'h00};
        vecs[24] = '{16'hFBFF, 16'hFBFF, 1'b0, 3'd3, 16'hFBFF, 5'h05};
        vecs[25] = '{16'h3C00, 16'hBC00, 1'b1, 3'd0, 16'h4000, 5'h00};
        vecs[26] = '{16'h8000, 16'h0000, 1'b0, 3'd0, 16'h0000, 5'h00};
        vecs[27] = '{16'h8000, 16'h0000, 1'b0, 3'd2, 16'h8000, 5'h00};
        vecs[28] = '{16'h7BFF, 16'h7BFF, 1'b0, 3'd4, 16'h7C00, 5'h05};
        vecs[29] = '{16'h7BFF, 16'h7BFF, 1'b0, 3'd3, 16'h7C00, 5'h05};
        vecs[30] = '{16'h3C00, 16'h7C01, 1'b0, 3'd0, 16'h7E00, 5'h10};
        vecs[31] = '{16'h4200, 16'hBC00, 1'b0, 3'd0, 16'h4000, 5'h00};
        vecs[32] = '{16'h3C00, 16'h0001, 1'b0, 3'd2, 16'h3C00, 5'h01};
        vecs[33] = '{16'hBC00, 16'h8001, 1'b0, 3'd2, 16'hBC01, 5'h01};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_result", {16'b0, result}, 32'd0);
        chk("rst_fflags", {27'b0, fflags}, 32'd0);
        chk("rst_ctrl", ctrl_out, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // Latency: out_valid rises exactly 3 cycles after the transfer cycle
        send(vecs[0], 32'h0000_1000);
        chk("lat_cycle1", {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;
        chk("lat_cycle2", {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;
        chk("lat_cycle3", {31'b0, out_valid}, 32'd1);
        drain("drain_latency");

        // Full table back-to-back
        for (int i = 0; i < NV; i++) send(vecs[i], 32'(i));
        drain("drain_table");

        // 8-op stream with a 5-cycle output stall in the middle
        fork
            begin
                for (int i = 0; i < 8; i++) send(vecs[i], 32'hA0 + 32'(i));
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                @(negedge clk);
                chk("stall_in_ready_low", {31'b0, in_ready}, 32'd0);
                chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain("drain_stream");

        // Reset with two ops in flight: nothing may emerge afterwards
        send(vecs[3], 32'h0000_0B01);
        send(vecs[8], 32'h0000_0B02);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        chk("midrst_result", {16'b0, result}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("midrst_no_valid", {31'b0, out_valid}, 32'd0);
        end
        @(posedge clk); #1;

        // Recovery after reset
        send(vecs[9], 32'h0000_0C01);
        drain("drain_recover");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
